// File: rtl/occupancy_pkg.sv
// occupancy_pkg
//   Shared types and constants for the doorway front end of the occupancy tracker.
//   door_state_e : direction FSM states
//   BEAM_CLEAR / BEAM_BROKEN : beam levels (1 = beam interrupted)
//   is_passage() : true for the states that belong to a passage in progress
package occupancy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IN_O,
    IN_OI,
    IN_I,
    OUT_I,
    OUT_IO,
    OUT_O,
    WAIT_CLR
  } door_state_e;

  localparam logic BEAM_CLEAR  = 1'b0;
  localparam logic BEAM_BROKEN = 1'b1;

  // Passage states are the only ones subject to the timeout.
  function automatic logic is_passage(input door_state_e s);
    return (s != IDLE) && (s != WAIT_CLR);
  endfunction

endpackage

// File: rtl/beam_debouncer.sv
// beam_debouncer
//   Brings one raw beam-break signal into the clk domain through a 2-FF
//   synchroniser, then accepts a new level only after the synchronised value
//   has differed from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
//   Raw change -> beam_level change latency is 2 + DEBOUNCE_CYCLES cycles.
// Ports
//   clk        in  system clock
//   rst_n      in  asynchronous reset, active-low (level returns to clear)
//   beam_raw   in  raw beam, 1 = broken, asynchronous to clk
//   beam_level out debounced beam level
module beam_debouncer
  import occupancy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic beam_raw,
  output logic beam_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= BEAM_CLEAR;
      sync2_reg <= BEAM_CLEAR;
      level_reg <= BEAM_CLEAR;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= beam_raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg != level_reg) begin
        // The sample that reaches CNT_LAST is the DEBOUNCE_CYCLES-th
        // consecutive differing one, so the level is taken here.
        if (cnt_reg == CNT_LAST) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end
      end else begin
        // Any reversion to the accepted level restarts the qualification.
        cnt_reg <= '0;
      end
    end
  end

  assign beam_level = level_reg;

endmodule

// File: rtl/doorway_direction_detector.sv
// doorway_direction_detector
//   Turns the outer/inner beam-break sensors of a doorway into single-cycle
//   entry/exit pulses for the occupancy tracker. Each beam is synchronised and
//   debounced, then a direction FSM follows the ordered break/clear sequence.
//   A passage that lingers too long, or both beams breaking at once from idle,
//   raises seq_fault and waits for the doorway to clear without counting.
// Ports
//   clk          in  system clock
//   rst_n        in  asynchronous reset, active-low
//   beam_outer   in  raw outer beam, 1 = broken
//   beam_inner   in  raw inner beam, 1 = broken
//   entry_sensor out 1-cycle pulse: completed outer->inner passage
//   exit_sensor  out 1-cycle pulse: completed inner->outer passage
//   seq_fault    out 1-cycle pulse: timeout or ambiguous sequence
module doorway_direction_detector
  import occupancy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic beam_outer,
  input  logic beam_inner,
  output logic entry_sensor,
  output logic exit_sensor,
  output logic seq_fault
);

  localparam int BEAM_OUTER_IDX = 0;
  localparam int BEAM_INNER_IDX = 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  logic [1:0] raw_vec;
  logic [1:0] level_vec;
  logic [1:0] beams_oi;  // {outer, inner} debounced

  assign raw_vec = {beam_inner, beam_outer};

  for (genvar gi = 0; gi < 2; gi++) begin : g_beam
    beam_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk       (clk),
      .rst_n     (rst_n),
      .beam_raw  (raw_vec[gi]),
      .beam_level(level_vec[gi])
    );
  end

  assign beams_oi = {level_vec[BEAM_OUTER_IDX], level_vec[BEAM_INNER_IDX]};

  door_state_e      state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             entry_reg, entry_next;
  logic             exit_reg, exit_next;
  logic             fault_reg, fault_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      entry_reg <= 1'b0;
      exit_reg  <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      entry_reg <= entry_next;
      exit_reg  <= exit_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    entry_next = 1'b0;
    exit_next  = 1'b0;
    fault_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        case (beams_oi)
          2'b10: state_next = IN_O;
          2'b01: state_next = OUT_I;
          2'b11: begin
            // Both beams at once gives no direction information.
            state_next = WAIT_CLR;
            fault_next = 1'b1;
          end
          default: ;
        endcase
      end
      IN_O: begin
        case (beams_oi)
          2'b11:   state_next = IN_OI;
          2'b00:   state_next = IDLE;  // backed out
          2'b01:   state_next = IN_I;
          default: ;
        endcase
      end
      IN_OI: begin
        case (beams_oi)
          2'b01:   state_next = IN_I;
          2'b10:   state_next = IN_O;
          2'b00:   state_next = IDLE;
          default: ;
        endcase
      end
      IN_I: begin
        case (beams_oi)
          2'b00: begin
            state_next = IDLE;
            entry_next = 1'b1;
          end
          2'b11:   state_next = IN_OI;
          2'b10:   state_next = IN_O;
          default: ;
        endcase
      end
      OUT_I: begin
        case (beams_oi)
          2'b11:   state_next = OUT_IO;
          2'b00:   state_next = IDLE;
          2'b10:   state_next = OUT_O;
          default: ;
        endcase
      end
      OUT_IO: begin
        case (beams_oi)
          2'b10:   state_next = OUT_O;
          2'b01:   state_next = OUT_I;
          2'b00:   state_next = IDLE;
          default: ;
        endcase
      end
      OUT_O: begin
        case (beams_oi)
          2'b00: begin
            state_next = IDLE;
            exit_next  = 1'b1;
          end
          2'b11:   state_next = OUT_IO;
          2'b01:   state_next = OUT_I;
          default: ;
        endcase
      end
      WAIT_CLR: begin
        if (beams_oi == 2'b00) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A genuine transition in the same cycle wins over the timeout; the timer
    // restarts on it anyway.
    if (is_passage(state_reg) && (state_next == state_reg) && (timer_reg == TMR_LAST)) begin
      state_next = WAIT_CLR;
      fault_next = 1'b1;
    end

    if ((state_next != state_reg) || !is_passage(state_reg)) begin
      timer_next = '0;
    end else begin
      timer_next = timer_reg + TMR_ONE;
    end
  end

  assign entry_sensor = entry_reg;
  assign exit_sensor  = exit_reg;
  assign seq_fault    = fault_reg;

endmodule
